// File: rtl/fp8_add_arbiter.sv
// Two-requester round-robin front end for one shared FP8 adder: one operation
// in flight, enable window sized to ADD_LAT, result returned to the issuer.
module fp8_add_arbiter #(
  parameter int ADD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_en,
  input  logic [7:0] add_sum,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(ADD_LAT);

  state_t     state;
  logic       lg;
  logic       gid;
  logic [2:0] cnt;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] res;

  logic       idle;
  logic       win;
  logic       grant_vld;

  // On a tie the requester that did not win last time takes the grant.
  assign idle       = (state == IDLE);
  assign win        = req1_valid & (~req0_valid | ~lg);
  assign grant_vld  = idle & (req0_valid | req1_valid);
  assign req0_ready = idle & req0_valid & ~win;
  assign req1_ready = idle & req1_valid & win;

  assign add_a      = op_a;
  assign add_b      = op_b;
  assign add_en     = (state == WAIT);
  assign busy       = ~idle;
  assign rsp0_valid = (state == RESP) & ~gid;
  assign rsp1_valid = (state == RESP) & gid;
  assign rsp0_data  = res;
  assign rsp1_data  = res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lg    <= 1'b1;
      gid   <= 1'b0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_a  <= win ? req1_a : req0_a;
            op_b  <= win ? req1_b : req0_b;
            gid   <= win;
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            res   <= add_sum;
            state <= RESP;
          end
        end
        RESP: begin
          if (gid ? rsp1_ready : rsp0_ready) begin
            lg    <= gid;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Bench for fp8_add_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model (ADD_LAT=1, plus ADD_LAT=0).
module tb_fp8_add_arbiter;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data, add_a, add_b, add_sum, sum_r;
  logic       add_en, busy;

  logic       z_req0_valid, z_req0_ready, z_req1_valid, z_req1_ready;
  logic [7:0] z_req0_a, z_req0_b, z_req1_a, z_req1_b;
  logic       z_rsp0_valid, z_rsp0_ready, z_rsp1_valid, z_rsp1_ready;
  logic [7:0] z_rsp0_data, z_rsp1_data, z_add_a, z_add_b, z_add_sum;
  logic       z_add_en, z_busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Registered adder stub for the ADD_LAT=1 instance, combinational for ADD_LAT=0.
  always_ff @(posedge clk) if (add_en) sum_r <= add_a + add_b;
  assign add_sum   = sum_r;
  assign z_add_sum = z_add_a + z_add_b;

  fp8_add_arbiter #(.ADD_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_sum(add_sum), .busy(busy)
  );

  fp8_add_arbiter #(.ADD_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(z_req0_valid), .req0_ready(z_req0_ready), .req0_a(z_req0_a), .req0_b(z_req0_b),
    .req1_valid(z_req1_valid), .req1_ready(z_req1_ready), .req1_a(z_req1_a), .req1_b(z_req1_b),
    .rsp0_valid(z_rsp0_valid), .rsp0_ready(z_rsp0_ready), .rsp0_data(z_rsp0_data),
    .rsp1_valid(z_rsp1_valid), .rsp1_ready(z_rsp1_ready), .rsp1_data(z_rsp1_data),
    .add_a(z_add_a), .add_b(z_add_b), .add_en(z_add_en), .add_sum(z_add_sum), .busy(z_busy)
  );

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic wait_rdy(input bit id, input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic drain;
    bit done;
    idle_inputs();
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (busy === 1'b0) done = 1'b1;
      else tick();
    end
    chk("drain_busy", busy, 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_add_en", add_en, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_z_busy", z_busy, 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    bit   ok;
    int   lat;
    int   ng;
    int   gcyc[4];
    int   gids[4];
    // model state for the randomized run
    bit         m_pend, m_gid, m_lg, e_win, e_rv, e_en, e_busy, e_idle, grant, done;
    logic [7:0] m_a, m_b, e_sum;
    int         m_gc;

    tbl[0] = '{id: 1'b0, a: 8'h38, b: 8'h30, sum: 8'h68};
    tbl[1] = '{id: 1'b1, a: 8'hFF, b: 8'h01, sum: 8'h00};
    tbl[2] = '{id: 1'b0, a: 8'hC0, b: 8'h50, sum: 8'h10};
    tbl[3] = '{id: 1'b1, a: 8'h7F, b: 8'h01, sum: 8'h80};
    tbl[4] = '{id: 1'b0, a: 8'h12, b: 8'h34, sum: 8'h46};

    rst_n = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    z_req0_valid = 1'b0; z_req1_valid = 1'b0;
    z_req0_a = '0; z_req0_b = '0; z_req1_a = '0; z_req1_b = '0;
    z_rsp0_ready = 1'b0; z_rsp1_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request, cycle by cycle
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h38; req0_b = 8'h30;
    #1;
    chk("t1_req0_ready_T", req0_ready, 1);
    chk("t1_busy_T", busy, 0);
    chk("t1_add_en_T", add_en, 0);
    tick(); req0_valid = 1'b0; #1;
    chk("t1_add_en_T1", add_en, 1);
    chk("t1_busy_T1", busy, 1);
    chk("t1_add_a_T1", add_a, 8'h38);
    chk("t1_add_b_T1", add_b, 8'h30);
    tick(); #1;
    chk("t1_add_en_T2", add_en, 1);
    chk("t1_rsp0_valid_T2", rsp0_valid, 0);
    tick(); #1;
    chk("t1_rsp0_valid_T3", rsp0_valid, 1);
    chk("t1_rsp0_data_T3", rsp0_data, 8'h68);
    chk("t1_rsp1_valid_T3", rsp1_valid, 0);
    chk("t1_busy_T3", busy, 1);
    chk("t1_add_en_T3", add_en, 0);
    tick(); #1;
    chk("t1_busy_T4", busy, 0);
    chk("t1_rsp0_valid_T4", rsp0_valid, 0);
    tick();

    // Vector table of isolated transactions
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (tbl[i].id) begin
        req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b;
      end else begin
        req0_valid = 1'b1; req0_a = tbl[i].a; req0_b = tbl[i].b;
      end
      wait_rdy(tbl[i].id, 12, ok);
      chk("tbl_grant", ok, 1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat = 1; ok = 1'b0;
      for (int k = 0; k < 12 && !ok; k++) begin
        #1;
        if ((tbl[i].id ? rsp1_valid : rsp0_valid) === 1'b1) ok = 1'b1;
        else begin tick(); lat++; end
      end
      chk("tbl_rsp_seen", ok, 1);
      chk("tbl_latency", lat, LAT + 2);
      chk("tbl_data", tbl[i].id ? rsp1_data : rsp0_data, tbl[i].sum);
      chk("tbl_other_valid", tbl[i].id ? rsp0_valid : rsp1_valid, 0);
      tick();
    end
    drain();

    // Tie from reset: alternating grants at the minimum issue interval
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h01; req0_b = 8'h01; req1_a = 8'h02; req1_b = 8'h02;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      chk("tie_single_ready", int'(req0_ready & req1_ready), 0);
      if (req0_ready || req1_ready) begin
        gids[ng] = int'(req1_ready);
        gcyc[ng] = c;
        ng++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_grant_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
      chk("tie_grant_id", gids[i], i % 2);
      if (i > 0) chk("tie_interval", gcyc[i] - gcyc[i-1], LAT + 3);
    end
    drain();

    // Response backpressure on requester 1
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h22;
    wait_rdy(1'b1, 12, ok);
    chk("bp_grant", ok, 1);
    tick();
    req1_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (rsp1_valid === 1'b1) ok = 1'b1;
      else tick();
    end
    chk("bp_rsp_seen", ok, 1);
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = k[0];
      #1;
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_data", rsp1_data, 8'h32);
      chk("bp_rsp0_valid", rsp0_valid, 0);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp1_valid, 1);
    chk("bp_release_req_ready", int'(req0_ready | req1_ready), 0);
    tick(); #1;
    chk("bp_after_valid", rsp1_valid, 0);
    chk("bp_after_busy", busy, 0);
    tick();

    // Reset during WAIT
    idle_inputs();
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06;
    wait_rdy(1'b0, 12, ok);
    chk("mr_grant", ok, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("mr_in_wait", add_en, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_add_en", add_en, 0);
    chk("mr_rsp0_valid", rsp0_valid, 0);
    chk("mr_rsp1_valid", rsp1_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("mr_no_rsp", int'(rsp0_valid | rsp1_valid | busy), 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mr_tie_req0", req0_ready, 1);
    chk("mr_tie_req1", req1_ready, 0);
    tick();
    drain();

    // req1 pulses once while busy and is never served
    req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h03;
    wait_rdy(1'b0, 12, ok);
    chk("gl_grant", ok, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
    #1;
    chk("gl_req1_ready_busy", req1_ready, 0);
    tick();
    req1_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("gl_no_rsp1", rsp1_valid, 0);
      chk("gl_no_req1_ready", req1_ready, 0);
      if (rsp0_valid === 1'b1) ok = 1'b1;
      tick();
    end
    chk("gl_rsp0_seen", ok, 1);
    drain();

    // Combinational adder with ADD_LAT=0
    z_rsp0_ready = 1'b1;
    z_req0_valid = 1'b1; z_req0_a = 8'h01; z_req0_b = 8'h02;
    #1;
    chk("z_req0_ready", z_req0_ready, 1);
    tick();
    z_req0_valid = 1'b0;
    #1;
    chk("z_add_en_T1", z_add_en, 1);
    chk("z_rsp0_valid_T1", z_rsp0_valid, 0);
    tick(); #1;
    chk("z_add_en_T2", z_add_en, 0);
    chk("z_rsp0_valid_T2", z_rsp0_valid, 1);
    chk("z_rsp0_data_T2", z_rsp0_data, 8'h03);
    tick(); #1;
    chk("z_busy_T3", z_busy, 0);
    tick();

    // Randomized traffic against a transaction-level model
    do_reset();
    m_pend = 1'b0; m_gid = 1'b0; m_lg = 1'b1; m_a = '0; m_b = '0; m_gc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      e_idle = !m_pend;
      if (req0_valid && req1_valid) e_win = !m_lg;
      else e_win = req1_valid;
      e_rv   = m_pend && (cyc >= m_gc + LAT + 2);
      e_en   = m_pend && (cyc >= m_gc + 1) && (cyc <= m_gc + 1 + LAT);
      e_busy = m_pend && (cyc > m_gc);
      e_sum  = m_a + m_b;
      chk("rnd_req0_ready", req0_ready, int'(e_idle && req0_valid && !e_win));
      chk("rnd_req1_ready", req1_ready, int'(e_idle && req1_valid && e_win));
      chk("rnd_add_en", add_en, int'(e_en));
      chk("rnd_busy", busy, int'(e_busy));
      chk("rnd_rsp0_valid", rsp0_valid, int'(e_rv && !m_gid));
      chk("rnd_rsp1_valid", rsp1_valid, int'(e_rv && m_gid));
      if (e_en) begin
        chk("rnd_add_a", add_a, m_a);
        chk("rnd_add_b", add_b, m_b);
      end
      if (e_rv) chk("rnd_rsp_data", m_gid ? rsp1_data : rsp0_data, e_sum);
      grant = e_idle && (req0_valid || req1_valid);
      done  = e_rv && (m_gid ? rsp1_ready : rsp0_ready);
      tick();
      if (grant) begin
        m_pend = 1'b1;
        m_gid  = e_win;
        m_a    = e_win ? req1_a : req0_a;
        m_b    = e_win ? req1_b : req0_b;
        m_gc   = cyc;
      end
      if (done) begin
        m_pend = 1'b0;
        m_lg   = m_gid;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp8_add_arbiter.md
# fp8_add_arbiter

Round-robin arbiter and sequencer that shares one FP8 adder (1 sign, 4 exponent, 3 mantissa bits) between two requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the shared adder with an enable window sized to the adder's latency. It captures the sum and returns it to the originating requester over a second valid/ready handshake. It sits between client logic and the adder instance; the adder's own output register and enable are driven only by this block.

## Interface
- ADD_LAT, 1, adder latency in cycles from operands presented (with add_en high) to add_sum valid; legal range 0..6 (0 = combinational adder).

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  8  requester 0 FP8 operands
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  8  FP8 sum
- rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1
- add_a, add_b  out  8  operands to shared adder
- add_en  out  1  adder enable
- add_sum  in  8  adder result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. Single outstanding operation.
- IDLE
  - The grant is computed combinationally from req*_valid and the last-grant pointer lg.
  - If only one requester is valid, it wins.
  - If both are valid, the one not equal to lg wins.
  - reqN_ready = 1 only for the winner, only in IDLE.
  - On handshake, register: op_a and op_b from that requester; gid = winner; cnt = ADD_LAT; next state WAIT.
- WAIT
  - add_en = 1; add_a/add_b = op_a/op_b.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, register res = add_sum, then go to RESP.
- RESP
  - rsp[gid]_valid = 1; the other rsp_valid stays 0.
  - Hold until rsp[gid]_ready = 1.
  - On that handshake: lg = gid; go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- add_a/add_b always show op_a/op_b. add_en is 0 outside WAIT.
- rsp0_data and rsp1_data both show res at all times. The data is meaningful only while the matching valid is high.
- Requesters may deassert valid without being granted. A requester is not latched or queued while not granted.
- No req*_ready is asserted outside IDLE, including in the cycle the FSM returns from RESP to IDLE.
- Reset state:
  - state = IDLE; lg = 1, so requester 0 wins the first tie.
  - op_a, op_b, res, gid, cnt = 0.
  - All outputs 0, including busy.
- Reset mid-operation: the operation is abandoned, no rsp_valid is produced, and the block returns to the reset state on the next edge.

## Timing
- Handshake at cycle T (IDLE, valid & ready).
- WAIT occupies cycles T+1 .. T+1+ADD_LAT, with add_en high throughout.
- add_sum is sampled at the edge ending cycle T+1+ADD_LAT.
- rsp valid from cycle T+2+ADD_LAT. If rsp_ready is already high, the response handshake completes in that same cycle, and IDLE follows in the next cycle.
- Minimum issue interval is ADD_LAT+3 cycles.
- busy is high from T+1 through the response-handshake cycle.
- All outputs except req*_ready are registered-state decodes. req*_ready is combinational from req*_valid, lg and state.

## Test plan
- Bench uses an adder stub that returns add_a+add_b mod 256, registered when add_en is high, with ADD_LAT=1. Stimulus: single request, req0 a=0x38, b=0x30, rsp0_ready tied high.
  - Required: req0_ready in cycle T; add_en high in T+1 and T+2; rsp0_valid in T+3 with data 0x68; rsp1_valid stays 0; busy high T+1..T+3.
- Tie from reset: req0 and req1 both valid every cycle.
  - Required: grants alternate 0,1,0,1 starting with 0; each grant is separated by ADD_LAT+3 cycles.
- Response backpressure: rsp1_ready held low for 5 cycles after rsp1_valid rises.
  - Required: rsp1_valid and rsp1_data stay stable; no req*_ready asserts; pulsing rsp0_ready has no effect.
- ADD_LAT=0 with a combinational stub: a=0x01, b=0x02.
  - Required: WAIT lasts 1 cycle; rsp valid at T+2 with 0x03.
- rst_n pulled low in a WAIT cycle.
  - Required: next cycle state is IDLE; busy, all rsp_valid and add_en are 0; the next tie grants requester 0.
- req1 valid for one cycle while busy, then dropped.
  - Required: never granted; no spurious rsp1_valid.
